// File: rtl/is31fl3731_pkg.sv
// Shared register constants, FSM state encoding and command record for the
// IS31FL3731 frame driver.
package is31fl3731_pkg;

    localparam logic [7:0] REG_CMD      = 8'hFD;
    localparam logic [7:0] REG_SHUTDOWN = 8'h0A;
    localparam logic [7:0] PAGE_FUNC    = 8'h0B;
    localparam logic [7:0] PAGE_FRAME0  = 8'h00;
    localparam logic [7:0] REG_PWM_BASE = 8'h24;
    localparam int         PWM_REGS     = 144;
    localparam int         ENABLE_REGS  = 18;

    typedef enum logic [3:0] {
        S_POWER_UP,
        S_SEL_FUNC,
        S_UNSHUTDOWN,
        S_SEL_FRAME,
        S_ENABLES,
        S_CLEAR,
        S_IDLE,
        S_SCAN,
        S_SEND,
        S_AWAIT
    } state_t;

    typedef enum int {
        MAP_SCROLL_HAT = 0,
        MAP_LINEAR     = 1
    } map_mode_t;

    typedef struct packed {
        logic [7:0] loc;
        logic [7:0] data;
        logic [7:0] rep;
    } i2c_cmd_t;

endpackage

// File: rtl/is31fl3731_led_map.sv
// Combinational (col,row) -> PWM register offset (0..143) for the chosen
// matrix layout.
module is31fl3731_led_map import is31fl3731_pkg::*; #(
    parameter int NUM_COLS = 17,
    parameter int NUM_ROWS = 7,
    parameter int MAP_MODE = 0
) (
    input  logic [$clog2(NUM_COLS)-1:0] col,
    input  logic [$clog2(NUM_ROWS)-1:0] row,
    output logic [7:0]                  pwm_idx
);

    int c, r, v;

    // Scroll HAT Mini: left half of the panel sits mirrored on matrix A,
    // right half runs forward on matrix B.
    always_comb begin
        c = int'(col);
        r = int'(row);
        v = 0;
        if (MAP_MODE == int'(MAP_LINEAR))
            v = c * 8 + r;
        else if (c < 9)
            v = 16 * (8 - c) + (6 - r);
        else
            v = 16 * (c - 9) + 8 + r;
        pwm_idx = 8'(v);
    end

endmodule

// File: rtl/is31fl3731_frame_driver.sv
// IS31FL3731 frame driver: power-up/init sequence, host-written framebuffer
// with dirty tracking, and change-only streaming with bounded retry.
module is31fl3731_frame_driver import is31fl3731_pkg::*; #(
    parameter int         NUM_COLS        = 17,
    parameter int         NUM_ROWS        = 7,
    parameter int         MAP_MODE        = 0,
    parameter logic [6:0] I2C_ADDR        = 7'h74,
    parameter int         REPEAT_SZ       = 6,
    parameter int         POWER_UP_CYCLES = 50_000_000,
    parameter int         CLEAR_CHUNK     = 36,
    parameter int         MAX_RETRY       = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pix_we,
    input  logic [$clog2(NUM_COLS)-1:0] pix_x,
    input  logic [$clog2(NUM_ROWS)-1:0] pix_y,
    input  logic [7:0]                  pix_value,
    output logic                        ready,
    output logic                        frame_done,
    output logic [7:0]                  err_count,
    output logic [6:0]                  i2c_address,
    output logic                        i2c_activate,
    output logic [7:0]                  i2c_location,
    output logic [7:0]                  i2c_data,
    output logic [REPEAT_SZ-1:0]        i2c_repeat,
    input  logic                        i2c_busy,
    input  logic                        i2c_success,
    input  logic                        i2c_abort
);

    localparam int N      = NUM_COLS * NUM_ROWS;
    localparam int IW     = (N > 1) ? $clog2(N) : 1;
    localparam int CW     = $clog2(NUM_COLS);
    localparam int RW     = $clog2(NUM_ROWS);
    localparam int NCHUNK = PWM_REGS / CLEAR_CHUNK;
    localparam logic [7:0] EN_MASK = 8'((1 << NUM_ROWS) - 1);

    state_t          state, ret_state;
    logic [31:0]     delay;
    logic            en_step;
    logic [7:0]      clr_cnt, clr_loc;
    logic [IW-1:0]   scan_idx;
    logic [CW-1:0]   scan_col;
    logic [RW-1:0]   scan_row;
    logic [7:0]      retry;
    logic            seen_busy, aborted, sent;
    logic [7:0]      fb [N];
    logic [N-1:0]    dirty;
    logic            in_range, scan_take, cmd_go;
    logic [IW-1:0]   wr_idx;
    logic [7:0]      map_idx;
    i2c_cmd_t        cmd;
    state_t          cmd_ret;
    logic            unused_success;

    assign i2c_address    = I2C_ADDR;
    assign unused_success = i2c_success;

    is31fl3731_led_map #(
        .NUM_COLS (NUM_COLS),
        .NUM_ROWS (NUM_ROWS),
        .MAP_MODE (MAP_MODE)
    ) u_map (
        .col     (scan_col),
        .row     (scan_row),
        .pwm_idx (map_idx)
    );

    assign in_range  = (int'(pix_x) < NUM_COLS) && (int'(pix_y) < NUM_ROWS);
    assign wr_idx    = IW'(int'(pix_x) * NUM_ROWS + int'(pix_y));
    assign scan_take = (state == S_SCAN) && dirty[scan_idx];

    // Host write is applied after the scan's clear so a same-pixel write
    // in the take cycle keeps the pixel dirty for the next pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            dirty <= '0;
            for (int i = 0; i < N; i++) fb[i] <= '0;
        end else begin
            if (scan_take) dirty[scan_idx] <= 1'b0;
            if (pix_we && in_range) begin
                fb[wr_idx]    <= pix_value;
                dirty[wr_idx] <= 1'b1;
            end
        end
    end

    // Next command to issue from the current sequencing state.
    always_comb begin
        cmd_go  = 1'b0;
        cmd     = '0;
        cmd_ret = S_IDLE;
        case (state)
            S_SEL_FUNC: begin
                cmd_go = 1'b1; cmd = '{REG_CMD, PAGE_FUNC, 8'd0}; cmd_ret = S_UNSHUTDOWN;
            end
            S_UNSHUTDOWN: begin
                cmd_go = 1'b1; cmd = '{REG_SHUTDOWN, 8'h01, 8'd0}; cmd_ret = S_SEL_FRAME;
            end
            S_SEL_FRAME: begin
                cmd_go = 1'b1; cmd = '{REG_CMD, PAGE_FRAME0, 8'd0}; cmd_ret = S_ENABLES;
            end
            S_ENABLES: begin
                if (!en_step) begin
                    cmd_go  = 1'b1;
                    cmd_ret = S_ENABLES;
                    if (MAP_MODE == int'(MAP_LINEAR))
                        cmd = '{8'h00, EN_MASK, 8'(NUM_COLS - 1)};
                    else
                        cmd = '{8'h00, 8'h7F, 8'(ENABLE_REGS - 2)};
                end else begin
                    cmd_ret = S_CLEAR;
                    if (MAP_MODE == int'(MAP_LINEAR)) begin
                        cmd_go = (NUM_COLS < ENABLE_REGS);
                        cmd    = '{8'(NUM_COLS), 8'h00, 8'(ENABLE_REGS - NUM_COLS - 1)};
                    end else begin
                        cmd_go = 1'b1;
                        cmd    = '{8'(ENABLE_REGS - 1), 8'h00, 8'd0};
                    end
                end
            end
            S_CLEAR: begin
                cmd_go  = 1'b1;
                cmd     = '{clr_loc, 8'h00, 8'(CLEAR_CHUNK - 1)};
                cmd_ret = (clr_cnt == 8'(NCHUNK - 1)) ? S_IDLE : S_CLEAR;
            end
            S_SCAN: begin
                cmd_go  = dirty[scan_idx];
                cmd     = '{REG_PWM_BASE + map_idx, fb[scan_idx], 8'd0};
                cmd_ret = S_SCAN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_POWER_UP;
            ret_state    <= S_IDLE;
            delay        <= 32'(POWER_UP_CYCLES);
            ready        <= 1'b0;
            frame_done   <= 1'b0;
            err_count    <= '0;
            i2c_activate <= 1'b0;
            i2c_location <= '0;
            i2c_data     <= '0;
            i2c_repeat   <= '0;
            en_step      <= 1'b0;
            clr_cnt      <= '0;
            clr_loc      <= REG_PWM_BASE;
            scan_idx     <= '0;
            scan_col     <= '0;
            scan_row     <= '0;
            retry        <= '0;
            seen_busy    <= 1'b0;
            aborted      <= 1'b0;
            sent         <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (cmd_go) begin
                i2c_location <= cmd.loc;
                i2c_data     <= cmd.data;
                i2c_repeat   <= REPEAT_SZ'(cmd.rep);
                ret_state    <= cmd_ret;
                retry        <= '0;
                state        <= S_SEND;
            end
            case (state)
                S_POWER_UP: begin
                    if (delay == '0) state <= S_SEL_FUNC;
                    else             delay <= delay - 1'b1;
                end
                S_ENABLES: begin
                    en_step <= ~en_step;
                    if (en_step && !cmd_go) state <= S_CLEAR;
                end
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    clr_loc <= clr_loc + 8'(CLEAR_CHUNK);
                end
                S_IDLE: begin
                    ready <= 1'b1;
                    state <= S_SCAN;
                end
                S_SCAN: begin
                    if (cmd_go) sent <= 1'b1;
                    else if (~|dirty && sent) begin
                        frame_done <= 1'b1;
                        sent       <= 1'b0;
                    end
                    // Advance even when sending so the return resumes at idx+1.
                    if (scan_idx == IW'(N - 1)) begin
                        scan_idx <= '0;
                        scan_col <= '0;
                        scan_row <= '0;
                    end else if (scan_row == RW'(NUM_ROWS - 1)) begin
                        scan_idx <= scan_idx + 1'b1;
                        scan_row <= '0;
                        scan_col <= scan_col + 1'b1;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                        scan_row <= scan_row + 1'b1;
                    end
                end
                S_SEND: begin
                    if (!i2c_busy) begin
                        i2c_activate <= 1'b1;
                        seen_busy    <= 1'b0;
                        aborted      <= 1'b0;
                        state        <= S_AWAIT;
                    end
                end
                S_AWAIT: begin
                    if (i2c_abort) aborted <= 1'b1;
                    if (i2c_busy) begin
                        i2c_activate <= 1'b0;
                        seen_busy    <= 1'b1;
                    end else if (seen_busy) begin
                        if (aborted || i2c_abort) begin
                            if (retry < 8'(MAX_RETRY)) begin
                                retry <= retry + 1'b1;
                                state <= S_SEND;
                            end else begin
                                if (err_count != 8'hFF) err_count <= err_count + 1'b1;
                                state <= ret_state;
                            end
                        end else begin
                            state <= ret_state;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
